// File: rtl/led_fade_engine_pkg.sv
// Shared constants, field layout and FSM state type for the LED fade engine.
package led_fade_engine_pkg;

    localparam int NLEDS    = 12;
    localparam int REG_CTRL = 12;
    localparam int WORD_W   = 29;

    localparam int RR_LSB = 0;
    localparam int GG_LSB = 8;
    localparam int BB_LSB = 16;
    localparam int LL_LSB = 24;
    localparam int LL_W   = 5;

    localparam logic [2:0] FRAME_PREFIX = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STEP,
        ST_WRITE,
        ST_WAIT,
        ST_NEXT
    } state_e;

    function automatic logic [31:0] frame_word(input logic [WORD_W-1:0] w);
        return {FRAME_PREFIX, w};
    endfunction

endpackage

// File: rtl/led_fade_engine_fade_step.sv
// Combinational stepper: moves every {LL, B, G, R} field one count toward its target.
module fade_step
    import led_fade_engine_pkg::*;
(
    input  logic [WORD_W-1:0] cur_i,
    input  logic [WORD_W-1:0] tgt_i,
    output logic [WORD_W-1:0] next_o,
    output logic              changed_o
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_field
            localparam int LSB = (gi == 0) ? RR_LSB :
                                 (gi == 1) ? GG_LSB :
                                 (gi == 2) ? BB_LSB : LL_LSB;
            localparam int W   = (gi == 3) ? LL_W : 8;

            logic [W-1:0] c;
            logic [W-1:0] t;
            assign c = cur_i[LSB +: W];
            assign t = tgt_i[LSB +: W];
            // Saturating by construction: only moves while strictly short of the target.
            assign next_o[LSB +: W] = (c < t) ? c + 1'b1 :
                                      (c > t) ? c - 1'b1 : c;
        end
    endgenerate

    assign changed_o = (next_o != cur_i);

endmodule

// File: rtl/led_fade_engine.sv
// Fade controller: CPU-programmed targets, ticked stepping of current LED words,
// and a Wishbone master pushing each changed word to the LED frame RAM.
module led_fade_engine
    import led_fade_engine_pkg::*;
#(
    parameter logic [7:0] ADDR     = 8'h00,
    parameter logic [7:0] LED_ADDR = 8'h00
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        wb_dbus_cyc,
    input  logic        wb_dbus_we,
    input  logic [31:0] wb_dbus_adr,
    input  logic [31:0] wb_dbus_dat,
    output logic        ack,
    output logic        m_cyc,
    output logic        m_we,
    output logic [31:0] m_adr,
    output logic [31:0] m_dat,
    input  logic        m_ack,
    output logic        busy
);

    logic              ack_q;
    logic              served_q;
    logic              ack_d;
    logic              wr_en;
    logic [3:0]        reg_idx;

    logic              enable_q;
    logic [15:0]       div_q;
    logic [15:0]       cnt_q;
    logic              tick;
    logic              pending_q;

    state_e            state_q;
    state_e            state_d;
    logic              pass_start;
    logic [3:0]        idx_q;
    logic [WORD_W-1:0] cur_q;
    logic [WORD_W-1:0] tgt_q;
    logic [31:0]       madr_q;
    logic [31:0]       mdat_q;

    logic [WORD_W-1:0] target_q  [NLEDS];
    logic [WORD_W-1:0] current_q [NLEDS];

    logic [WORD_W-1:0] step_next;
    logic              step_changed;

    logic              unused_bits;
    assign unused_bits = &{1'b0, wb_dbus_adr[23:6], wb_dbus_adr[1:0], wb_dbus_dat[30:29]};

    // One ack per cyc assertion: served_q blocks re-acking until the CPU drops cyc.
    assign ack_d   = wb_dbus_cyc && (wb_dbus_adr[31:24] == ADDR) && !ack_q && !served_q;
    assign wr_en   = ack_d && wb_dbus_we;
    assign reg_idx = wb_dbus_adr[5:2];

    assign tick = enable_q && (cnt_q == div_q);

    fade_step u_fade_step (
        .cur_i     (cur_q),
        .tgt_i     (tgt_q),
        .next_o    (step_next),
        .changed_o (step_changed)
    );

    always_comb begin
        state_d    = state_q;
        pass_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    pass_start = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD:  state_d = ST_STEP;
            ST_STEP:  state_d = step_changed ? ST_WRITE : ST_NEXT;
            ST_WRITE: state_d = ST_WAIT;
            ST_WAIT:  if (m_ack) state_d = ST_NEXT;
            ST_NEXT:  state_d = (idx_q == 4'(NLEDS - 1)) ? ST_IDLE : ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            ack_q     <= 1'b0;
            served_q  <= 1'b0;
            enable_q  <= 1'b0;
            div_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cur_q     <= '0;
            tgt_q     <= '0;
            madr_q    <= '0;
            mdat_q    <= '0;
            for (int i = 0; i < NLEDS; i++) begin
                target_q[i]  <= '0;
                current_q[i] <= '0;
            end
        end else begin
            ack_q    <= ack_d;
            served_q <= wb_dbus_cyc && (served_q || ack_d);

            if (!enable_q || tick) cnt_q <= '0;
            else                   cnt_q <= cnt_q + 16'd1;

            // A tick coinciding with a pass start re-arms for the following pass.
            pending_q <= pass_start ? tick : (pending_q || tick);

            if (wr_en) begin
                if (reg_idx < 4'(NLEDS)) begin
                    target_q[reg_idx] <= wb_dbus_dat[WORD_W-1:0];
                end else if (reg_idx == 4'(REG_CTRL)) begin
                    enable_q <= wb_dbus_dat[31];
                    div_q    <= wb_dbus_dat[15:0];
                end
            end

            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (pending_q) idx_q <= '0;
                ST_LOAD: begin
                    cur_q <= current_q[idx_q];
                    tgt_q <= target_q[idx_q];
                end
                ST_STEP: begin
                    if (step_changed) begin
                        current_q[idx_q] <= step_next;
                        madr_q           <= {LED_ADDR, 18'b0, idx_q, 2'b00};
                        mdat_q           <= frame_word(step_next);
                    end
                end
                ST_NEXT: if (idx_q != 4'(NLEDS - 1)) idx_q <= idx_q + 4'd1;
                default: ;
            endcase
        end
    end

    assign ack   = ack_q;
    assign m_cyc = (state_q == ST_WRITE) || (state_q == ST_WAIT);
    assign m_we  = m_cyc;
    assign m_adr = madr_q;
    assign m_dat = mdat_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_fade_engine.sv
// Directed self-checking bench for led_fade_engine.
module tb_led_fade_engine;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic        wb_dbus_cyc = 1'b0;
    logic        wb_dbus_we = 1'b0;
    logic [31:0] wb_dbus_adr = '0;
    logic [31:0] wb_dbus_dat = '0;
    logic        ack;
    logic        m_cyc;
    logic        m_we;
    logic [31:0] m_adr;
    logic [31:0] m_dat;
    logic        m_ack = 1'b0;
    logic        busy;

    logic        stall = 1'b0;
    logic [63:0] wq[$];
    int          checks = 0;
    int          errors = 0;

    always #5 wb_clk = ~wb_clk;

    led_fade_engine dut (
        .wb_clk      (wb_clk),
        .wb_rst      (wb_rst),
        .wb_dbus_cyc (wb_dbus_cyc),
        .wb_dbus_we  (wb_dbus_we),
        .wb_dbus_adr (wb_dbus_adr),
        .wb_dbus_dat (wb_dbus_dat),
        .ack         (ack),
        .m_cyc       (m_cyc),
        .m_we        (m_we),
        .m_adr       (m_adr),
        .m_dat       (m_dat),
        .m_ack       (m_ack),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s %h", tag, got);
        end
    endtask

    // LED peripheral model: single ack one cycle after m_cyc, unless stalled.
    always @(posedge wb_clk) begin
        if (wb_rst || stall) m_ack <= 1'b0;
        else                 m_ack <= m_cyc && !m_ack;
    end

    always @(negedge wb_clk) begin
        if (!wb_rst && m_cyc && m_ack) begin
            wq.push_back({m_adr, m_dat});
            check("m_we", {31'b0, m_we}, 32'd1);
        end
    end

    task automatic cpu_write(input string tag, input logic [31:0] adr,
                             input logic [31:0] dat, input logic exp_ack);
        logic got;
        @(negedge wb_clk);
        wb_dbus_cyc = 1'b1;
        wb_dbus_we  = 1'b1;
        wb_dbus_adr = adr;
        wb_dbus_dat = dat;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge wb_clk);
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        wb_dbus_cyc = 1'b0;
        wb_dbus_we  = 1'b0;
        check(tag, {31'b0, got}, {31'b0, exp_ack});
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && wq.size() < n; i++) @(negedge wb_clk);
        check(tag, {31'b0, wq.size() >= n}, 32'd1);
    endtask

    task automatic wait_cyc(input string tag);
        int i;
        for (i = 0; i < 400 && !m_cyc; i++) @(negedge wb_clk);
        check(tag, {31'b0, m_cyc}, 32'd1);
    endtask

    initial begin
        logic [63:0] e;
        logic [31:0] a0, d0;
        int n, bad;
        logic prev;

        repeat (3) @(negedge wb_clk);
        wb_rst = 1'b0;
        @(negedge wb_clk);
        check("rst_ack",   {31'b0, ack},   32'd0);
        check("rst_m_cyc", {31'b0, m_cyc}, 32'd0);
        check("rst_m_we",  {31'b0, m_we},  32'd0);
        check("rst_m_adr", m_adr, 32'd0);
        check("rst_m_dat", m_dat, 32'd0);
        check("rst_busy",  {31'b0, busy},  32'd0);

        // Basic fade of LED 0.
        cpu_write("ack_t0", 32'h0000_0000, 32'h1F00_0002, 1'b1);
        cpu_write("ack_ctrl", 32'h0000_0030, 32'h8000_0000, 1'b1);
        wait_writes("fade_3w", 3, 400);
        e = wq[0]; check("w0_dat", e[31:0], 32'hE100_0001); check("w0_adr", e[63:32], 32'h0);
        e = wq[1]; check("w1_dat", e[31:0], 32'hE200_0002); check("w1_adr", e[63:32], 32'h0);
        e = wq[2]; check("w2_dat", e[31:0], 32'hE300_0002);

        // Freeze, make target equal current, measure an idle-write pass.
        cpu_write("ack_dis", 32'h0000_0030, 32'h0000_0000, 1'b1);
        repeat (200) @(negedge wb_clk);
        e = wq[wq.size()-1];
        cpu_write("ack_t0eq", 32'h0000_0000, {3'b000, e[28:0]}, 1'b1);
        wq.delete();
        cpu_write("ack_en", 32'h0000_0030, 32'h8000_0000, 1'b1);
        for (int i = 0; i < 100 && busy; i++) @(negedge wb_clk);
        for (int i = 0; i < 100 && !busy; i++) @(negedge wb_clk);
        n = 0;
        for (int i = 0; i < 200 && busy; i++) begin n++; @(negedge wb_clk); end
        check("pass_len", n, 32'd36);
        repeat (150) @(negedge wb_clk);
        check("eq_no_writes", wq.size(), 32'd0);

        // R on LED 1 up to 0x80, then one step down to 0x7F.
        cpu_write("ack_t1", 32'h0000_0004, 32'h0000_0080, 1'b1);
        n = 0;
        for (int i = 0; i < 9000; i++) begin
            @(negedge wb_clk);
            if (wq.size() > 0 && wq[wq.size()-1] == {32'h4, 32'hE000_0080}) begin
                n = 1;
                break;
            end
        end
        check("r_reach_80", n, 32'd1);
        wq.delete();
        cpu_write("ack_t1b", 32'h0000_0004, 32'h0000_007F, 1'b1);
        repeat (200) @(negedge wb_clk);
        check("down_count", wq.size(), 32'd1);
        if (wq.size() > 0) begin
            e = wq[0];
            check("down_dat", e[31:0], 32'hE000_007F);
            check("down_adr", e[63:32], 32'h0000_0004);
        end

        // Stalled m_ack with DIV=9: outputs stable, at most one pending pass.
        stall = 1'b1;
        cpu_write("ack_div9", 32'h0000_0030, 32'h8000_0009, 1'b1);
        cpu_write("ack_t2", 32'h0000_0008, 32'h0000_0001, 1'b1);
        wait_cyc("stall_cyc");
        a0 = m_adr; d0 = m_dat;
        check("stall_dat", d0, 32'hE000_0001);
        check("stall_adr", a0, 32'h0000_0008);
        bad = 0;
        repeat (50) begin
            @(negedge wb_clk);
            if (!m_cyc || m_adr !== a0 || m_dat !== d0) bad++;
        end
        check("stall_stable", bad, 32'd0);
        cpu_write("ack_dis2", 32'h0000_0030, 32'h0000_0000, 1'b1);
        stall = 1'b0;
        prev = busy; n = 0;
        repeat (300) begin
            @(negedge wb_clk);
            if (busy && !prev) n++;
            prev = busy;
        end
        check("pending_passes", n, 32'd1);

        // Reset while waiting on m_ack.
        wq.delete();
        stall = 1'b1;
        cpu_write("ack_t3", 32'h0000_000C, 32'h0000_0005, 1'b1);
        cpu_write("ack_en2", 32'h0000_0030, 32'h8000_0000, 1'b1);
        wait_cyc("wait_cyc");
        @(negedge wb_clk);
        wb_rst = 1'b1;
        @(posedge wb_clk); #1;
        check("rst_wait_cyc",  {31'b0, m_cyc}, 32'd0);
        check("rst_wait_busy", {31'b0, busy},  32'd0);
        @(negedge wb_clk);
        wb_rst = 1'b0;
        stall  = 1'b0;
        wq.delete();
        cpu_write("ack_t0c", 32'h0000_0000, 32'h0000_0001, 1'b1);
        cpu_write("ack_en3", 32'h0000_0030, 32'h8000_0000, 1'b1);
        wait_writes("post_rst_w", 1, 300);
        if (wq.size() > 0) begin
            e = wq[0];
            check("post_rst_dat", e[31:0], 32'hE000_0001);
            check("post_rst_adr", e[63:32], 32'h0);
        end
        repeat (200) @(negedge wb_clk);
        check("post_rst_cnt", wq.size(), 32'd1);

        // Unused register index and foreign select.
        wq.delete();
        cpu_write("ack_idx14", 32'h0000_0038, 32'h1FFF_FFFF, 1'b1);
        cpu_write("ack_foreign", 32'h0100_0000, 32'h0000_0005, 1'b0);
        repeat (200) @(negedge wb_clk);
        check("no_state_chg", wq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
